// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, RAM lane masks,
// controller state codes and size helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd1;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_mask = MASK_BYTE;
      SZ_HALF: size_mask = MASK_HALF;
      SZ_WORD: size_mask = MASK_WORD;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-pipeline side request/response bus of the load/store unit.
interface lsu_mem_ctrl_if #(parameter int W = 32);
  logic         lsu_req;
  logic         lsu_ready;
  logic         lsu_we;
  logic [1:0]   lsu_size;
  logic         lsu_unsigned;
  logic [W-1:0] lsu_addr;
  logic [W-1:0] lsu_wdata;
  logic         lsu_done;
  logic         lsu_err;
  logic [W-1:0] lsu_rdata;

  modport master (
    output lsu_req, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
    input  lsu_ready, lsu_done, lsu_err, lsu_rdata
  );

  modport slave (
    input  lsu_req, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
    output lsu_ready, lsu_done, lsu_err, lsu_rdata
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Zero/sign extension of a raw little-endian RAM word to the load result.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] raw_word,
  input  logic [1:0]   size,
  input  logic         is_unsigned,
  output logic [W-1:0] ext_word
);

  // Select the low lanes for the access size and fill above them.
  always_comb begin
    ext_word = raw_word;
    case (size)
      SZ_BYTE: ext_word = {{(W-8){~is_unsigned & raw_word[7]}}, raw_word[7:0]};
      SZ_HALF: ext_word = {{(W-16){~is_unsigned & raw_word[15]}}, raw_word[15:0]};
      default: ext_word = raw_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: one request at a time, IDLE -> ISSUE -> RESP, faulted
// requests skip the RAM. Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int W = 32,
  parameter int H = 8
) (
  input  logic          clk,
  input  logic          rst,
  lsu_mem_ctrl_if.slave lsu,
  output logic [W-1:0]  ram_addr,
  output logic [W-1:0]  ram_wdat,
  output logic          ram_we,
  output logic          ram_re,
  output logic [3:0]    ram_type,
  output logic          sign,
  input  logic [W-1:0]  data_reg
);

  logic [1:0]   state_r;
  logic         we_r;
  logic [1:0]   size_r;
  logic         uns_r;
  logic         ready_r;
  logic         done_r;
  logic         err_r;
  logic [W-1:0] rdata_r;

  logic [2:0]   nbytes_s;
  logic [H:0]   end_s;
  logic         size_err_s;
  logic         range_err_s;
  logic         align_err_s;
  logic         fault_s;
  logic [W-1:0] ext_s;

  assign lsu.lsu_ready = ready_r;
  assign lsu.lsu_done  = done_r;
  assign lsu.lsu_err   = err_r;
  assign lsu.lsu_rdata = rdata_r;

  // Fault decision on the request presented at the accepting edge.
  always_comb begin
    nbytes_s    = size_bytes(lsu.lsu_size);
    end_s       = {1'b0, lsu.lsu_addr[H-1:0]} + {{(H-2){1'b0}}, nbytes_s - 3'd1};
    size_err_s  = (lsu.lsu_size == SZ_ILL);
    // Last byte must stay inside the RAM; carry into bit H means wrap-around.
    range_err_s = (lsu.lsu_addr[W-1:H] != {(W-H){1'b0}}) || end_s[H];
`ifdef LSU_MISALIGN_TRAP_EN
    align_err_s = ((lsu.lsu_size == SZ_HALF) && lsu.lsu_addr[0]) ||
                  ((lsu.lsu_size == SZ_WORD) && (lsu.lsu_addr[1:0] != 2'b00));
`else
    align_err_s = 1'b0;
`endif
    fault_s     = size_err_s || range_err_s || align_err_s;
  end

  lsu_load_extend #(.W(W)) u_extend (
    .raw_word    (data_reg),
    .size        (size_r),
    .is_unsigned (uns_r),
    .ext_word    (ext_s)
  );

  // Controller state and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      we_r     <= 1'b0;
      size_r   <= SZ_BYTE;
      uns_r    <= 1'b0;
      ready_r  <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= {W{1'b0}};
      ram_addr <= {W{1'b0}};
      ram_wdat <= {W{1'b0}};
      ram_we   <= 1'b0;
      ram_re   <= 1'b0;
      ram_type <= 4'b0000;
      sign     <= 1'b0;
    end else begin
      sign <= 1'b0;
      case (state_r)
        IDLE: begin
          done_r  <= 1'b0;
          err_r   <= 1'b0;
          rdata_r <= {W{1'b0}};
          if (lsu.lsu_req && ready_r) begin
            we_r    <= lsu.lsu_we;
            size_r  <= lsu.lsu_size;
            uns_r   <= lsu.lsu_unsigned;
            ready_r <= 1'b0;
            if (fault_s) begin
              state_r <= RESP;
              done_r  <= 1'b1;
              err_r   <= 1'b1;
            end else begin
              state_r  <= ISSUE;
              ram_addr <= lsu.lsu_addr;
              ram_wdat <= lsu.lsu_we ? lsu.lsu_wdata : {W{1'b0}};
              ram_we   <= lsu.lsu_we;
              ram_re   <= ~lsu.lsu_we;
              // Loads always fetch the raw full word; extension happens here.
              ram_type <= lsu.lsu_we ? size_mask(lsu.lsu_size) : MASK_WORD;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        ISSUE: begin
          state_r  <= RESP;
          ram_addr <= {W{1'b0}};
          ram_wdat <= {W{1'b0}};
          ram_we   <= 1'b0;
          ram_re   <= 1'b0;
          ram_type <= 4'b0000;
          done_r   <= 1'b1;
          err_r    <= 1'b0;
          rdata_r  <= we_r ? {W{1'b0}} : ext_s;
        end
        RESP: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
          rdata_r <= {W{1'b0}};
        end
        default: begin
          state_r  <= IDLE;
          ready_r  <= 1'b0;
          done_r   <= 1'b0;
          err_r    <= 1'b0;
          rdata_r  <= {W{1'b0}};
          ram_addr <= {W{1'b0}};
          ram_wdat <= {W{1'b0}};
          ram_we   <= 1'b0;
          ram_re   <= 1'b0;
          ram_type <= 4'b0000;
        end
      endcase
    end
  end

endmodule
